// File: rtl/cmp_minmax_tracker_pkg.sv
// rtl/cmp_minmax_tracker_pkg.sv - shared compare codes and tracker state encoding
package cmp_minmax_tracker_pkg;

    localparam logic [1:0] CMP_EQ = 2'b01;
    localparam logic [1:0] CMP_GT = 2'b10;
    localparam logic [1:0] CMP_LT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_signed_code.sv
// rtl/cmp_signed_code.sv - combinational signed compare producing the 2-bit compare code
module cmp_signed_code
    import cmp_minmax_tracker_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [1:0]   code
);

    // Two's-complement ordering; 2'b00 is never produced
    always_comb begin
        code = CMP_LT;
        if (a == b) begin
            code = CMP_EQ;
        end else if ($signed(a) > $signed(b)) begin
            code = CMP_GT;
        end
    end

endmodule

// File: rtl/cmp_minmax_tracker.sv
// rtl/cmp_minmax_tracker.sv - framed signed-sample max/min/max-position tracker
module cmp_minmax_tracker
    import cmp_minmax_tracker_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_max,
    output logic [W-1:0]     out_min,
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_len,
    output logic             out_ovf
);

    localparam logic [CNT_W-1:0] LEN_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             hold_entry;
    logic [1:0]       code_max;
    logic [1:0]       code_min;

    logic [W-1:0]     acc_max;
    logic [W-1:0]     acc_min;
    logic [CNT_W-1:0] acc_idx;
    logic [CNT_W-1:0] acc_len;
    logic             acc_ovf;

    logic [W-1:0]     nxt_max;
    logic [W-1:0]     nxt_min;
    logic [CNT_W-1:0] nxt_idx;
    logic [CNT_W-1:0] nxt_len;
    logic             nxt_ovf;

    assign accept     = in_valid & in_ready;
    // Only IDLE/ACC accept, so a last-sample accept is exactly the HOLD entry
    assign hold_entry = accept & in_last;

    cmp_signed_code #(.W(W)) u_cmp_max (
        .a    (in_data),
        .b    (acc_max),
        .code (code_max)
    );

    cmp_signed_code #(.W(W)) u_cmp_min (
        .a    (in_data),
        .b    (acc_min),
        .code (code_min)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = in_last ? ST_HOLD : ST_ACC;
            ST_ACC:  if (accept && in_last) state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only (no input-to-output path)
    always_comb begin
        in_ready  = (state != ST_HOLD);
        out_valid = (state == ST_HOLD);
    end

    // Accumulator values after folding in the current sample
    always_comb begin
        nxt_max = acc_max;
        nxt_min = acc_min;
        nxt_idx = acc_idx;
        nxt_len = acc_len;
        nxt_ovf = acc_ovf;
        if (state == ST_IDLE) begin
            nxt_max = in_data;
            nxt_min = in_data;
            nxt_idx = '0;
            nxt_len = CNT_W'(1);
            nxt_ovf = 1'b0;
        end else begin
            // Strictly greater only, so ties keep the first occurrence
            if (code_max == CMP_GT) begin
                nxt_max = in_data;
                nxt_idx = acc_len;
            end
            if (code_min == CMP_LT) begin
                nxt_min = in_data;
            end
            if (acc_len == LEN_MAX) begin
                nxt_ovf = 1'b1;
            end else begin
                nxt_len = acc_len + CNT_W'(1);
            end
        end
    end

    // Accumulators track the frame in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_max <= '0;
            acc_min <= '0;
            acc_idx <= '0;
            acc_len <= '0;
            acc_ovf <= 1'b0;
        end else if (accept) begin
            acc_max <= nxt_max;
            acc_min <= nxt_min;
            acc_idx <= nxt_idx;
            acc_len <= nxt_len;
            acc_ovf <= nxt_ovf;
        end
    end

    // Result registers load once per frame and persist until the next frame ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_max     <= '0;
            out_min     <= '0;
            out_max_idx <= '0;
            out_len     <= '0;
            out_ovf     <= 1'b0;
        end else if (hold_entry) begin
            out_max     <= nxt_max;
            out_min     <= nxt_min;
            out_max_idx <= nxt_idx;
            out_len     <= nxt_len;
            out_ovf     <= nxt_ovf;
        end
    end

endmodule

// File: tb/tb_cmp_minmax_tracker.sv
// tb/tb_cmp_minmax_tracker.sv - self-checking bench for cmp_minmax_tracker
module tb_cmp_minmax_tracker;

    localparam int W     = 4;
    localparam int CNT_W = 3;
    localparam int LIM   = (1 << CNT_W) - 1;
    localparam int RW    = 2 * W + 2 * CNT_W + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_max;
    logic [W-1:0]     out_min;
    logic [CNT_W-1:0] out_max_idx;
    logic [CNT_W-1:0] out_len;
    logic             out_ovf;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] frm[$];

    always #5 clk = ~clk;

    cmp_minmax_tracker #(.W(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_max     (out_max),
        .out_min     (out_min),
        .out_max_idx (out_max_idx),
        .out_len     (out_len),
        .out_ovf     (out_ovf)
    );

    function automatic logic [RW-1:0] result_vec();
        return {out_max, out_min, out_max_idx, out_len, out_ovf};
    endfunction

    // Reference: plain signed max/min over the whole frame, first index of max, clipped counts
    function automatic logic [RW-1:0] model(input logic [W-1:0] q[$]);
        int mx, mn, ix, v, n;
        mx = $signed(q[0]);
        mn = mx;
        ix = 0;
        n  = q.size();
        for (int i = 1; i < n; i++) begin
            v = $signed(q[i]);
            if (v > mx) begin mx = v; ix = i; end
            if (v < mn) mn = v;
        end
        return {W'(mx), W'(mn), CNT_W'((ix > LIM) ? LIM : ix),
                CNT_W'((n > LIM) ? LIM : n), 1'(n > LIM)};
    endfunction

    // Offer one sample and wait (bounded) until it is taken; returns at posedge+1
    task automatic push(input logic [W-1:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < frm.size(); i++) push(frm[i], i == frm.size() - 1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({out_valid, result_vec()} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h required 0", {out_valid, result_vec()});
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        push(4'd3, 1'b0);
        push(4'd7, 1'b0);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, result_vec()} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %h required 0", {out_valid, result_vec()});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(4'd2, 1'b1);
        vectors++;
        if ({out_valid, result_vec()} !== {1'b1, 4'd2, 4'd2, 3'd0, 3'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_next_frame: got %h required %h", {out_valid, result_vec()},
                     {1'b1, 4'd2, 4'd2, 3'd0, 3'd1, 1'b0});
        end
        take_result();
    endtask

    task automatic test_mixed_signs();
        frm = '{4'b0000, 4'b0001, 4'b1000, 4'b0111, 4'b0011};
        push_frame();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mixed_latency: out_valid=%b required 1", out_valid);
        end
        vectors++;
        if (result_vec() !== {4'b0111, 4'b1000, 3'd3, 3'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL mixed_result: got %h required %h", result_vec(),
                     {4'b0111, 4'b1000, 3'd3, 3'd5, 1'b0});
        end
        take_result();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL mixed_release: valid,ready=%b required 01", {out_valid, in_ready});
        end
        vectors++;
        if (result_vec() !== {4'b0111, 4'b1000, 3'd3, 3'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL mixed_held_after: got %h", result_vec());
        end
    endtask

    task automatic test_ties();
        frm = '{4'b0101, 4'b0101, 4'b0010};
        push_frame();
        vectors++;
        if ({out_valid, result_vec()} !== {1'b1, 4'b0101, 4'b0010, 3'd0, 3'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL ties_result: got %h required %h", {out_valid, result_vec()},
                     {1'b1, 4'b0101, 4'b0010, 3'd0, 3'd3, 1'b0});
        end
        take_result();
    endtask

    task automatic test_negatives();
        frm = '{4'b1010, 4'b1001};
        push_frame();
        vectors++;
        if ({out_valid, result_vec()} !== {1'b1, 4'b1010, 4'b1001, 3'd0, 3'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL negatives_result: got %h required %h", {out_valid, result_vec()},
                     {1'b1, 4'b1010, 4'b1001, 3'd0, 3'd2, 1'b0});
        end
        take_result();
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] held;
        frm = '{4'b0001, 4'b0110};
        push_frame();
        held = result_vec();
        in_valid = 1'b1;
        in_data  = 4'b0100;
        in_last  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({out_valid, in_ready, result_vec()} !== {2'b10, 4'b0110, 4'b0001, 3'd1, 3'd2, 1'b0}) begin
                miscompares++;
                $display("FAIL backpressure_hold c%0d: got %h held %h", c,
                         {out_valid, in_ready, result_vec()}, held);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL backpressure_release: valid,ready=%b required 01", {out_valid, in_ready});
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors++;
        if ({out_valid, result_vec()} !== {1'b1, 4'b0100, 4'b0100, 3'd0, 3'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL backpressure_next_frame: got %h required %h", {out_valid, result_vec()},
                     {1'b1, 4'b0100, 4'b0100, 3'd0, 3'd1, 1'b0});
        end
        @(posedge clk);
        #1;
        take_result();
    endtask

    task automatic test_overflow();
        logic [RW-1:0] exp;
        frm.delete();
        for (int i = 0; i < 8; i++) frm.push_back(W'($urandom_range(8, 14) + 2) & 4'hf);
        frm.push_back(4'b0111);
        exp = model(frm);
        push_frame();
        vectors++;
        if ({out_max, out_max_idx, out_len, out_ovf} !== {4'b0111, 3'd7, 3'd7, 1'b1}) begin
            miscompares++;
            $display("FAIL overflow_fixed: got %h required %h",
                     {out_max, out_max_idx, out_len, out_ovf}, {4'b0111, 3'd7, 3'd7, 1'b1});
        end
        vectors++;
        if (result_vec() !== exp) begin
            miscompares++;
            $display("FAIL overflow_model: got %h required %h", result_vec(), exp);
        end
        take_result();
    endtask

    task automatic test_random_frames();
        logic [RW-1:0] exp;
        logic [RW-1:0] snap;
        for (int f = 0; f < 25; f++) begin
            frm.delete();
            for (int i = 0; i < $urandom_range(1, 11); i++) frm.push_back(W'($urandom));
            exp = model(frm);
            push_frame();
            vectors++;
            if ({out_valid, result_vec()} !== {1'b1, exp}) begin
                miscompares++;
                $display("FAIL random_frame%0d len%0d: got %h required %h", f, frm.size(),
                         {out_valid, result_vec()}, {1'b1, exp});
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            take_result();
            snap = result_vec();
            vectors++;
            if ({out_valid, in_ready, snap} !== {2'b01, exp}) begin
                miscompares++;
                $display("FAIL random_release%0d: got %h required %h", f,
                         {out_valid, in_ready, snap}, {2'b01, exp});
            end
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_reset_mid_frame();
        test_mixed_signs();
        test_ties();
        test_negatives();
        test_backpressure();
        test_overflow();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmp_minmax_tracker.md
# cmp_minmax_tracker

Streaming signed-sample tracker. Consumes a framed stream of signed 4-bit samples over a valid/ready handshake and reports the frame's running maximum, minimum and max position. It uses the team's 2-bit signed compare code: 01 equal, 10 greater, 11 less. It sits downstream of the sample source and upstream of result logging/display, and reuses the signed comparison as a sub-module.

## Interface
Parameters:
- W, 4, sample width (two's complement)
- CNT_W, 8, frame length / index counter width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample present
- in_ready  out  1  tracker can accept a sample
- in_data  in  W  signed sample
- in_last  in  1  sample is the last of its frame
- out_valid  out  1  frame result present
- out_ready  in  1  consumer takes result
- out_max  out  W  largest sample (signed)
- out_min  out  W  smallest sample (signed)
- out_max_idx  out  CNT_W  0-based index of first occurrence of max
- out_len  out  CNT_W  samples in frame (saturating)
- out_ovf  out  1  frame longer than 2^CNT_W-1 samples

## Operation
- Accept = in_valid & in_ready. Combinational in_ready = (state != HOLD).
- States:
  - IDLE: no sample of current frame yet.
  - ACC: frame in progress.
  - HOLD: result presented.
- IDLE accept: max=min=in_data, max_idx=0, len=1, ovf=0. Go to ACC, or HOLD if in_last.
- ACC accept:
  - gt = cmp(in_data, max). Code 10 → max=in_data, max_idx=len. Codes 01/11 → keep. Ties keep first occurrence.
  - lt = cmp(in_data, min). Code 11 → min=in_data.
  - len+1 saturates at 2^CNT_W-1; ovf set sticky when a sample is accepted with len already saturated. max_idx takes saturated len.
  - in_last → HOLD.
- HOLD:
  - out_valid=1; out_* stable; no input accepted.
  - out_valid & out_ready → IDLE next edge.
- Compare is signed. 4'b1000 (-8) is below 4'b0001; 4'b1010 (-6) is below 4'b1001 (-7) is false (-6 > -7). Code 2'b00 never produced.
- out_* registers update only on the HOLD entry edge. They hold their value after the handshake until the next frame ends.

## Timing
- rst asserted (any time, including mid-frame or in HOLD):
  - state=IDLE
  - out_valid=0, out_max=0, out_min=0, out_max_idx=0, out_len=0, out_ovf=0
  - internal accumulators 0
  - in_ready=1 after release
  - partial frame discarded
- Latency: last sample accepted at edge N → out_valid=1 after edge N. The result includes that sample.
- Result handshake at edge M → out_valid=0 and in_ready=1 after M. First sample of the next frame can be accepted at edge M+1.
- Throughput: len+1 cycles per frame with no backpressure.
- in_last on first sample: single-sample frame, HOLD after one edge.
- in_valid while HOLD: ignored. The source must hold it (standard valid/ready). No data or state change.

## Structure
- Shared package: CMP_EQ=2'b01, CMP_GT=2'b10, CMP_LT=2'b11; state encoding IDLE/ACC/HOLD.
- Sub-module cmp_signed_code:
  - Combinational; parameter W; inputs a, b; output 2-bit code.
  - Instantiated twice (vs max, vs min).
- Top: state register, accumulators, saturating counter, output registers, async-reset always blocks.

## Test plan
- Reset mid-frame:
  - Stimulus: accept 3, 7; assert rst.
  - Required: all out_* = 0, out_valid=0.
  - Then frame 2, last → max=min=2, len=1, max_idx=0.
- Mixed signs:
  - Stimulus: 0000, 0001, 1000, 0111, 0011(last).
  - Required: max=0111 (7), min=1000 (-8), max_idx=3, len=5, ovf=0, out_valid one cycle after last.
- Ties:
  - Stimulus: 0101, 0101, 0010(last).
  - Required: max=0101, max_idx=0, min=0010, len=3.
- Negatives only:
  - Stimulus: 1010, 1001(last).
  - Required: max=1010 (-6), max_idx=0, min=1001 (-7).
- Backpressure:
  - Stimulus: out_ready low 3 cycles with in_valid high, data 0100.
  - Required: out_valid held, in_ready=0, outputs stable, no sample accepted.
  - After out_ready pulse: in_ready=1 next cycle, and 0100 is the first sample of the next frame.
- Overflow, CNT_W=3:
  - Stimulus: 9 samples, the 9th last and the largest.
  - Required: len=7, ovf=1, max_idx=7.
